nco_bcd_timer_disp: RTL and testbench

NCO_BCD_TIMER_DISP -- requirements
Module: nco_bcd_timer_disp

---
 rtl/nco_bcd_timer_disp.sv | 201 ++++++++++++++++++++
 tb/tb_nco_bcd_timer_disp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nco_bcd_timer_disp.sv
// NCO-paced BCD up/down counter with a multiplexed 7-segment display driver.
// Ports:
//   clk, rst (sync, active-high)
//   i_nco_step : tick-rate increment.
//   i_run, i_dir, i_wrap : counter control.
//   i_clr, i_load, i_load_val : preset.
//   o_cnt, o_term : count and terminal pulse.
//   o_seg, o_seg_dp, o_seg_enb : scanned display drive.
module nco_bcd_timer_disp #(
   parameter int DIGITS   = 6,
   parameter int NCO_W    = 32,
   parameter int SCAN_DIV = 50000,
   parameter int DP_POS   = 2,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCO_W-1:0]      i_nco_step,
   input  logic                  i_run,
   input  logic                  i_dir,
   input  logic                  i_wrap,
   input  logic                  i_clr,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_load_val,
   output logic [4*DIGITS-1:0]   o_cnt,
   output logic                  o_term,
   output logic [6:0]            o_seg,
   output logic                  o_seg_dp,
   output logic [DIGITS-1:0]     o_seg_enb
);

   localparam int CW = 4 * DIGITS;
   localparam int IW = $clog2(DIGITS);
   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] ALL9 = {DIGITS{4'h9}};

   logic [NCO_W-1:0]  r_acc;
   logic              r_tick;
   logic [CW-1:0]     r_cnt;
   logic              r_pend;
   logic              r_term;
   logic [DW-1:0]     r_div;
   logic [IW-1:0]     r_idx;
   logic [6:0]        r_seg;
   logic              r_dp;
   logic [DIGITS-1:0] r_enb;

   logic [NCO_W:0]    w_sum;
   logic [CW-1:0]     w_inc;
   logic [CW-1:0]     w_dec;
   logic [CW-1:0]     w_ld;
   logic [CW-1:0]     w_next;
   logic              w_next_term;
   logic              w_at_term;
   logic              w_step;
   logic [DIGITS-1:0] w_lz;
   logic [3:0]        w_dig;
   logic              w_blank;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      s = 7'h00;
      case (d)
         4'd0: s = 7'h3F;
         4'd1: s = 7'h06;
         4'd2: s = 7'h5B;
         4'd3: s = 7'h4F;
         4'd4: s = 7'h66;
         4'd5: s = 7'h6D;
         4'd6: s = 7'h7D;
         4'd7: s = 7'h07;
         4'd8: s = 7'h7F;
         4'd9: s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Tick is the registered carry-out of the phase accumulator.
   assign w_sum = {1'b0, r_acc} + {1'b0, i_nco_step};

   always_ff @(posedge clk) begin
      if (rst || i_clr || i_load) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_acc  <= w_sum[NCO_W-1:0];
         r_tick <= w_sum[NCO_W];
      end
   end

   // Decimal ripple increment/decrement and clamped preset.
   always_comb begin : bcd_arith
      logic c;
      logic b;
      logic [3:0] d;
      logic [3:0] l;
      w_inc = r_cnt;
      w_dec = r_cnt;
      w_ld  = '0;
      c = 1'b1;
      b = 1'b1;
      d = 4'd0;
      l = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         d = r_cnt[4*i +: 4];
         if (c) begin
            if (d == 4'd9) begin
               w_inc[4*i +: 4] = 4'd0;
            end else begin
               w_inc[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end
         if (b) begin
            if (d == 4'd0) begin
               w_dec[4*i +: 4] = 4'd9;
            end else begin
               w_dec[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end
         l = i_load_val[4*i +: 4];
         w_ld[4*i +: 4] = (l > 4'd9) ? 4'd9 : l;
      end
   end

   assign w_at_term   = i_dir ? (r_cnt == '0) : (r_cnt == ALL9);
   assign w_step      = r_tick & i_run & ~(w_at_term & ~i_wrap);
   assign w_next      = i_dir ? w_dec : w_inc;
   assign w_next_term = i_dir ? (w_dec == '0) : (w_inc == ALL9);

   // r_pend marks a counted arrival at terminal; o_term follows it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_pend <= 1'b0;
         r_term <= 1'b0;
      end else begin
         r_term <= r_pend;
         if (i_clr) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
         end else if (i_load) begin
            r_cnt  <= w_ld;
            r_pend <= 1'b0;
         end else if (w_step) begin
            r_cnt  <= w_next;
            r_pend <= w_next_term;
         end else begin
            r_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (r_div == DW'(SCAN_DIV - 1)) begin
         r_div <= '0;
         r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // w_lz[i]: digit i and every digit above it are zero.
   always_comb begin : lz_scan
      logic z;
      z = 1'b1;
      w_lz = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         z = z & (r_cnt[4*i +: 4] == 4'd0);
         w_lz[i] = z;
      end
   end

   assign w_dig   = r_cnt[4*r_idx +: 4];
   assign w_blank = (BLANK_LZ != 0) && w_lz[r_idx]
                    && (int'(r_idx) > DP_POS) && (r_idx != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg <= 7'h00;
         r_dp  <= 1'b0;
         r_enb <= '1;
      end else begin
         r_seg <= w_blank ? 7'h00 : seg7(w_dig);
         r_dp  <= (int'(r_idx) == DP_POS);
         r_enb <= ~(DIGITS'(1) << r_idx);
      end
   end

   assign o_cnt     = r_cnt;
   assign o_term    = r_term;
   assign o_seg     = r_seg;
   assign o_seg_dp  = r_dp;
   assign o_seg_enb = r_enb;

endmodule

// File: tb/tb_nco_bcd_timer_disp.sv
// Bench for nco_bcd_timer_disp: DIGITS=3, NCO_W=8, SCAN_DIV=4, DP_POS=1.
// Vector table for counting scenarios plus directed display/reset sequences.
module tb_nco_bcd_timer_disp;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_nco_step;
   logic        i_run;
   logic        i_dir;
   logic        i_wrap;
   logic        i_clr;
   logic        i_load;
   logic [11:0] i_load_val;
   logic [11:0] o_cnt;
   logic        o_term;
   logic [6:0]  o_seg;
   logic        o_seg_dp;
   logic [2:0]  o_seg_enb;

   int checks = 0;
   int errors = 0;
   int term_seen;

   always #5 clk = ~clk;

   nco_bcd_timer_disp #(
      .DIGITS(3), .NCO_W(8), .SCAN_DIV(4), .DP_POS(1), .BLANK_LZ(1)
   ) dut (
      .clk(clk), .rst(rst), .i_nco_step(i_nco_step), .i_run(i_run),
      .i_dir(i_dir), .i_wrap(i_wrap), .i_clr(i_clr), .i_load(i_load),
      .i_load_val(i_load_val), .o_cnt(o_cnt), .o_term(o_term),
      .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_seg_enb(o_seg_enb)
   );

   typedef struct {
      string       name;
      logic [11:0] ld;
      logic        dir;
      logic        wrap;
      logic        run;
      int          nt;
      logic [11:0] exp_cnt;
      int          exp_term;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         if (o_term) term_seen++;
      end
   endtask

   task automatic do_load(input logic [11:0] v, input logic d,
                          input logic w, input logic r);
      i_load_val = v;
      i_dir = d;
      i_wrap = w;
      i_run = r;
      i_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_load = 1'b0;
      term_seen = 0;
   endtask

   logic [2:0] prev_enb;
   logic [2:0] exp_nxt;
   int         runlen;
   bit         first_run;

   initial begin
      vecs[0]  = '{"up3",      12'h000, 0, 1, 1, 3,  12'h003, 0};
      vecs[1]  = '{"up998x1",  12'h998, 0, 1, 1, 1,  12'h999, 1};
      vecs[2]  = '{"upwrap",   12'h998, 0, 1, 1, 2,  12'h000, 1};
      vecs[3]  = '{"dnsat",    12'h001, 1, 0, 1, 3,  12'h000, 1};
      vecs[4]  = '{"upsat",    12'h998, 0, 0, 1, 4,  12'h999, 1};
      vecs[5]  = '{"dnwrap",   12'h000, 1, 1, 1, 1,  12'h999, 0};
      vecs[6]  = '{"upcarry",  12'h129, 0, 1, 1, 1,  12'h130, 0};
      vecs[7]  = '{"dnborrow", 12'h100, 1, 1, 1, 1,  12'h099, 0};
      vecs[8]  = '{"clamp",    12'hFA3, 0, 1, 0, 0,  12'h993, 0};
      vecs[9]  = '{"pause",    12'h555, 0, 1, 0, 20, 12'h555, 0};
      vecs[10] = '{"dn2",      12'h010, 1, 1, 1, 2,  12'h008, 0};

      rst = 1'b1;
      i_nco_step = 8'h00;
      i_run = 1'b0;
      i_dir = 1'b0;
      i_wrap = 1'b0;
      i_clr = 1'b0;
      i_load = 1'b0;
      i_load_val = 12'h000;
      term_seen = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cnt", 32'(o_cnt), 32'h000);
      chk("rst_term", 32'(o_term), 32'h0);
      chk("rst_enb", 32'(o_seg_enb), 32'h7);
      chk("rst_seg", 32'(o_seg), 32'h00);
      chk("rst_dp", 32'(o_seg_dp), 32'h0);
      rst = 1'b0;

      // Tick every 4 cycles: count changes 5 edges after clear, then every 4.
      i_nco_step = 8'h40;
      i_run = 1'b1;
      i_wrap = 1'b1;
      i_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_clr = 1'b0;
      cyc(4);
      chk("seq_t0", 32'(o_cnt), 32'h000);
      cyc(1);
      chk("seq_t1", 32'(o_cnt), 32'h001);
      cyc(4);
      chk("seq_t2", 32'(o_cnt), 32'h002);

      foreach (vecs[k]) begin
         do_load(vecs[k].ld, vecs[k].dir, vecs[k].wrap, vecs[k].run);
         cyc(4 * vecs[k].nt + 3);
         chk({vecs[k].name, "_cnt"}, 32'(o_cnt), 32'(vecs[k].exp_cnt));
         chk({vecs[k].name, "_term"}, 32'(term_seen),
             32'(vecs[k].exp_term));
      end

      // Clear beats load in the same cycle.
      i_load_val = 12'h555;
      i_load = 1'b1;
      i_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_load = 1'b0;
      i_clr = 1'b0;
      chk("clr_over_load", 32'(o_cnt), 32'h000);

      // Zero step: no ticks at all.
      i_nco_step = 8'h00;
      do_load(12'h005, 0, 1, 1);
      cyc(40);
      chk("step0", 32'(o_cnt), 32'h005);

      // Half-scale step: tick every second cycle.
      i_nco_step = 8'h80;
      do_load(12'h000, 0, 1, 1);
      cyc(21);
      chk("step_half", 32'(o_cnt), 32'h010);

      // Display of 007: digit2 blanked, digit1 shows 0 with dp.
      i_nco_step = 8'h00;
      do_load(12'h007, 0, 1, 0);
      cyc(2);
      prev_enb = o_seg_enb;
      runlen = 0;
      first_run = 1'b1;
      for (int c = 0; c < 24; c++) begin
         case (o_seg_enb)
            3'b110: begin
               chk("d0_seg", 32'(o_seg), 32'h07);
               chk("d0_dp", 32'(o_seg_dp), 32'h0);
            end
            3'b101: begin
               chk("d1_seg", 32'(o_seg), 32'h3F);
               chk("d1_dp", 32'(o_seg_dp), 32'h1);
            end
            3'b011: begin
               chk("d2_seg", 32'(o_seg), 32'h00);
               chk("d2_dp", 32'(o_seg_dp), 32'h0);
            end
            default: chk("enb_onehot", 32'(o_seg_enb), 32'h6);
         endcase
         if (o_seg_enb != prev_enb) begin
            exp_nxt = {prev_enb[1:0], prev_enb[2]};
            chk("enb_order", 32'(o_seg_enb), 32'(exp_nxt));
            if (!first_run) chk("enb_len", 32'(runlen), 32'd4);
            first_run = 1'b0;
            runlen = 1;
            prev_enb = o_seg_enb;
         end else begin
            runlen++;
         end
         cyc(1);
      end

      // Reset mid-scan at 123.
      do_load(12'h123, 0, 1, 0);
      cyc(6);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_cnt", 32'(o_cnt), 32'h000);
      chk("mrst_enb", 32'(o_seg_enb), 32'h7);
      chk("mrst_seg", 32'(o_seg), 32'h00);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cyc(1);
         chk("mrst_enb0", 32'(o_seg_enb), 32'h6);
         chk("mrst_seg0", 32'(o_seg), 32'h3F);
      end
      cyc(1);
      chk("mrst_enb1", 32'(o_seg_enb), 32'h5);
      chk("mrst_dp1", 32'(o_seg_dp), 32'h1);
      cyc(4);
      chk("mrst_enb2", 32'(o_seg_enb), 32'h3);
      chk("mrst_seg2", 32'(o_seg), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
